i2c_slave_emu: RTL and testbench

I2C_SLAVE_EMU -- requirements
Module: i2c_slave_emu

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_slv_sync.sv | 51 +++++
 rtl/i2c_slave_emu.sv | 274 +++++++++++++++++++++++++++
 tb/tb_i2c_slave_emu.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave emulator: FSM state encoding,
// ACK/NACK bit levels and the default data byte width.
package i2c_pkg;

    localparam int unsigned I2C_DATA_SZ_DFLT = 8;

    // Bus level of the acknowledge bit in the ninth clock
    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

    // FSM state encoding
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_DEV_ADDR = 4'd1;
    localparam logic [3:0] ST_DEV_ACK  = 4'd2;
    localparam logic [3:0] ST_REG_ADDR = 4'd3;
    localparam logic [3:0] ST_REG_ACK  = 4'd4;
    localparam logic [3:0] ST_WR_DATA  = 4'd5;
    localparam logic [3:0] ST_WR_ACK   = 4'd6;
    localparam logic [3:0] ST_RD_DATA  = 4'd7;
    localparam logic [3:0] ST_RD_ACK   = 4'd8;

endpackage

// File: rtl/i2c_slv_sync.sv
// SCL/SDA synchronizer with SCL edge and START/STOP condition detection.
// All outputs are derived from the synchronized copies of the bus lines.
module i2c_slv_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Synchronizer chains plus one delayed copy for edge detection; idle bus is high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // SDA may only move while SCL is stable high to form START/STOP
    always_comb begin
        sda_o      = sda_s;
        scl_rise_o = scl_s & ~scl_prev_q;
        scl_fall_o = ~scl_s & scl_prev_q;
        start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    end

endmodule

// File: rtl/i2c_slave_emu.sv
// I2C slave register-file emulator. Answers to SLV_ADDR, takes a register
// pointer byte after a write address, then writes or reads data bytes.
// Define I2C_SLV_AUTOINC_EN to advance the pointer after every data byte;
// without it every data byte of a transaction targets the same register.
module i2c_slave_emu
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLV_ADDR    = 7'h68,
    parameter int unsigned DATA_I2C_SZ = I2C_DATA_SZ_DFLT,
    parameter int unsigned REG_ADDR_SZ = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic                   I_SCL,
    input  logic                   I_SDA,
    output logic                   O_SDA_OE,
    input  logic                   I_WE,
    input  logic [REG_ADDR_SZ-1:0] I_WADDR,
    input  logic [DATA_I2C_SZ-1:0] I_WDATA,
    output logic                   O_WR_STB,
    output logic [REG_ADDR_SZ-1:0] O_WR_ADDR,
    output logic [DATA_I2C_SZ-1:0] O_WR_DATA,
    output logic                   O_BUSY,
    output logic                   O_NACK_FL,
    output logic                   O_WR_COLL
);

    localparam int DW    = DATA_I2C_SZ;
    localparam int DEPTH = 2 ** REG_ADDR_SZ;
    localparam int CNT_W = $clog2(DATA_I2C_SZ + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_I2C_SZ);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    logic [3:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]          shift_q, shift_d;
    logic [REG_ADDR_SZ-1:0] ptr_q, ptr_d, ptr_adv;
    logic                   ptr_set_q, ptr_set_d;
    logic                   rw_q, rw_d;
    logic                   mack_q, mack_d;
    logic                   oe_q, oe_d;
    logic                   busy_q, busy_d;

    logic [DW-1:0]          regs_q [DEPTH];
    logic [DW-1:0]          rd_byte_cur, rd_byte_next;
    logic                   i2c_wr, host_wr, coll, nack_pulse;
    logic                   rx_shift, byte_done;

    logic                   wr_stb_q, nack_q, coll_q;
    logic [REG_ADDR_SZ-1:0] wr_addr_q;
    logic [DW-1:0]          wr_data_q;

    i2c_slv_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i      (CLK),
        .rst_ni     (RST_n),
        .scl_i      (I_SCL),
        .sda_i      (I_SDA),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

`ifdef I2C_SLV_AUTOINC_EN
    assign ptr_adv = ptr_q + 1'b1;
`else
    assign ptr_adv = ptr_q;
`endif

    assign rd_byte_cur  = regs_q[ptr_q];
    assign rd_byte_next = regs_q[ptr_adv];
    assign rx_shift     = scl_rise && (cnt_q != CNT_FULL);
    assign byte_done    = scl_fall && (cnt_q == CNT_FULL);

    // Host write is dropped only when it collides with an I2C write to the same register
    assign coll    = I_WE && i2c_wr && (I_WADDR == ptr_q);
    assign host_wr = I_WE && !coll;

    // Protocol FSM; SDA drive decisions are taken only on SCL falling edges
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        ptr_set_d  = ptr_set_q;
        rw_d       = rw_q;
        mack_d     = mack_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        i2c_wr     = 1'b0;
        nack_pulse = 1'b0;
        if (start_det) begin
            state_d   = ST_DEV_ADDR;
            cnt_d     = '0;
            ptr_set_d = 1'b0;
            oe_d      = 1'b0;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_DEV_ADDR: begin
                    if (rx_shift) begin
                        shift_d = {shift_q[DW-2:0], sda_s};
                        cnt_d   = cnt_q + 1'b1;
                    end else if (byte_done) begin
                        cnt_d = '0;
                        if (shift_q[DW-1 -: 7] == SLV_ADDR) begin
                            state_d = ST_DEV_ACK;
                            rw_d    = shift_q[DW-8];
                            oe_d    = ~ACK_BIT;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_REG_ADDR: begin
                    if (rx_shift) begin
                        shift_d = {shift_q[DW-2:0], sda_s};
                        cnt_d   = cnt_q + 1'b1;
                    end else if (byte_done) begin
                        cnt_d     = '0;
                        ptr_d     = shift_q[REG_ADDR_SZ-1:0];
                        ptr_set_d = 1'b1;
                        state_d   = ST_REG_ACK;
                        oe_d      = ~ACK_BIT;
                    end
                end
                ST_WR_DATA: begin
                    if (rx_shift) begin
                        shift_d = {shift_q[DW-2:0], sda_s};
                        cnt_d   = cnt_q + 1'b1;
                    end else if (byte_done) begin
                        cnt_d   = '0;
                        i2c_wr  = 1'b1;
                        ptr_d   = ptr_adv;
                        state_d = ST_WR_ACK;
                        oe_d    = ~ACK_BIT;
                    end
                end
                ST_DEV_ACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (rw_q) begin
                            // Byte is latched here so host writes cannot disturb the shift
                            state_d = ST_RD_DATA;
                            shift_d = rd_byte_cur;
                            oe_d    = ~rd_byte_cur[DW-1];
                        end else begin
                            state_d = ptr_set_q ? ST_WR_DATA : ST_REG_ADDR;
                            oe_d    = 1'b0;
                        end
                    end
                end
                ST_REG_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        state_d = ST_WR_DATA;
                        cnt_d   = '0;
                        oe_d    = 1'b0;
                    end
                end
                ST_RD_DATA: begin
                    if (rx_shift) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (scl_fall) begin
                        if (cnt_q == CNT_FULL) begin
                            state_d = ST_RD_ACK;
                            cnt_d   = '0;
                            oe_d    = 1'b0;
                        end else if (cnt_q != '0) begin
                            shift_d = {shift_q[DW-2:0], 1'b0};
                            oe_d    = ~shift_q[DW-2];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        mack_d = sda_s;
                    end else if (scl_fall) begin
                        cnt_d = '0;
                        if (mack_q == ACK_BIT) begin
                            ptr_d   = ptr_adv;
                            shift_d = rd_byte_next;
                            oe_d    = ~rd_byte_next[DW-1];
                            state_d = ST_RD_DATA;
                        end else begin
                            nack_pulse = 1'b1;
                            oe_d       = 1'b0;
                            state_d    = ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM and datapath state
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            ptr_set_q <= 1'b0;
            rw_q      <= 1'b0;
            mack_q    <= NACK_BIT;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            ptr_set_q <= ptr_set_d;
            rw_q      <= rw_d;
            mack_q    <= mack_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
        end
    end

    // Register file; the I2C write is applied last so it wins on a shared address
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (host_wr) begin
                regs_q[I_WADDR] <= I_WDATA;
            end
            if (i2c_wr) begin
                regs_q[ptr_q] <= shift_q;
            end
        end
    end

    // Event pulses and the write report registers
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            nack_q    <= 1'b0;
            coll_q    <= 1'b0;
        end else begin
            wr_stb_q <= i2c_wr;
            nack_q   <= nack_pulse;
            coll_q   <= coll;
            if (i2c_wr) begin
                wr_addr_q <= ptr_q;
                wr_data_q <= shift_q;
            end
        end
    end

    assign O_SDA_OE  = oe_q;
    assign O_BUSY    = busy_q;
    assign O_WR_STB  = wr_stb_q;
    assign O_WR_ADDR = wr_addr_q;
    assign O_WR_DATA = wr_data_q;
    assign O_NACK_FL = nack_q;
    assign O_WR_COLL = coll_q;

endmodule

// File: tb/tb_i2c_slave_emu.sv
// Directed testbench for i2c_slave_emu: bit-banged I2C master, host preload
// port, pulse monitors and immediate-assertion checks.
module tb_i2c_slave_emu;

    localparam int Q = 4;  // system clocks per quarter SCL period

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       I_SCL = 1'b1;
    logic       m_sda = 1'b1;
    logic       I_SDA;
    logic       I_WE = 1'b0;
    logic [4:0] I_WADDR = '0;
    logic [7:0] I_WDATA = '0;
    logic       O_SDA_OE, O_WR_STB, O_BUSY, O_NACK_FL, O_WR_COLL;
    logic [4:0] O_WR_ADDR;
    logic [7:0] O_WR_DATA;

    int         n_vec = 0;
    int         n_err = 0;
    int         stb_n = 0, nack_n = 0, coll_n = 0, oe_n = 0, busy_n = 0;
    logic [4:0] last_waddr = '0;
    logic [7:0] last_wdata = '0;

    // Open-drain bus: slave pulls low when enabled
    assign I_SDA = m_sda & ~O_SDA_OE;

    always #5 CLK = ~CLK;

    i2c_slave_emu dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .I_SCL     (I_SCL),
        .I_SDA     (I_SDA),
        .O_SDA_OE  (O_SDA_OE),
        .I_WE      (I_WE),
        .I_WADDR   (I_WADDR),
        .I_WDATA   (I_WDATA),
        .O_WR_STB  (O_WR_STB),
        .O_WR_ADDR (O_WR_ADDR),
        .O_WR_DATA (O_WR_DATA),
        .O_BUSY    (O_BUSY),
        .O_NACK_FL (O_NACK_FL),
        .O_WR_COLL (O_WR_COLL)
    );

    always @(negedge CLK) begin
        if (O_WR_STB) begin
            stb_n      <= stb_n + 1;
            last_waddr <= O_WR_ADDR;
            last_wdata <= O_WR_DATA;
        end
        if (O_NACK_FL) nack_n <= nack_n + 1;
        if (O_WR_COLL) coll_n <= coll_n + 1;
        if (O_SDA_OE)  oe_n   <= oe_n + 1;
        if (O_BUSY)    busy_n <= busy_n + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Works both from idle and as a repeated START with SCL low
    task automatic i2c_start();
        m_sda = 1'b1; clks(Q);
        I_SCL = 1'b1; clks(Q);
        m_sda = 1'b0; clks(Q);
        I_SCL = 1'b0; clks(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; clks(Q);
        I_SCL = 1'b1; clks(Q);
        m_sda = 1'b1; clks(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    clks(Q);
        I_SCL = 1'b1; clks(2 * Q);
        I_SCL = 1'b0; clks(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; clks(Q);
        I_SCL = 1'b1; clks(Q);
        b = I_SDA;    clks(Q);
        I_SCL = 1'b0; clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic send_ack, output logic [7:0] d);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(send_ack);
    endtask

    // Last data bit places a host write to reg 3 in the cycle the slave commits the byte
    task automatic write_byte_coll(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 1; i--) write_bit(d[i]);
        m_sda = d[0]; clks(Q);
        I_SCL = 1'b1; clks(2 * Q);
        I_SCL = 1'b0; clks(2);
        I_WE = 1'b1; I_WADDR = 5'h03; I_WDATA = 8'h55;
        clks(1);
        I_WE = 1'b0;
        clks(Q - 3);
        read_bit(ack);
    endtask

    task automatic host_wr(input logic [4:0] a, input logic [7:0] d);
        I_WE = 1'b1; I_WADDR = a; I_WDATA = d;
        clks(1);
        I_WE = 1'b0;
        clks(1);
    endtask

    task automatic rd_reg(input logic [4:0] r, output logic [7:0] d);
        logic a;
        i2c_start();
        write_byte(8'hD0, a);
        write_byte({3'b000, r}, a);
        i2c_start();
        write_byte(8'hD1, a);
        read_byte(1'b1, d);
        i2c_stop();
        clks(4);
    endtask

    initial begin
        logic       a0, a1, a2;
        logic [7:0] d0, d1;
        logic [7:0] exp_b1, exp_r5, exp_r6;
        int         s_stb, s_nack, s_coll, s_oe, s_busy;

`ifdef I2C_SLV_AUTOINC_EN
        exp_b1 = 8'hB0; exp_r5 = 8'h11; exp_r6 = 8'h22;
`else
        exp_b1 = 8'hF0; exp_r5 = 8'h22; exp_r6 = 8'h00;
`endif

        // Reset state
        clks(3);
        chk("rst_sda_oe",  32'(O_SDA_OE),  32'd0);
        chk("rst_busy",    32'(O_BUSY),    32'd0);
        chk("rst_wr_stb",  32'(O_WR_STB),  32'd0);
        chk("rst_nack",    32'(O_NACK_FL), 32'd0);
        chk("rst_coll",    32'(O_WR_COLL), 32'd0);
        chk("rst_wr_addr", 32'(O_WR_ADDR), 32'd0);
        chk("rst_wr_data", 32'(O_WR_DATA), 32'd0);
        RST_n = 1'b1;
        clks(3);

        // Register write through I2C
        s_stb = stb_n;
        i2c_start();
        write_byte(8'hD0, a0);
        write_byte(8'h6B, a1);
        write_byte(8'h80, a2);
        clks(4);
        chk("wr_ack_dev",  32'(a0), 32'd0);
        chk("wr_ack_reg",  32'(a1), 32'd0);
        chk("wr_ack_data", 32'(a2), 32'd0);
        chk("wr_stb_cnt",  32'(stb_n - s_stb), 32'd1);
        chk("wr_addr",     32'(last_waddr), 32'h0B);
        chk("wr_data",     32'(last_wdata), 32'h80);
        chk("busy_in_xfer", 32'(O_BUSY), 32'd1);
        i2c_stop();
        clks(4);
        chk("busy_after_stop", 32'(O_BUSY), 32'd0);

        // Burst read across the pointer wrap point with repeated START
        host_wr(5'h1F, 8'hF0);
        host_wr(5'h00, 8'hB0);
        s_nack = nack_n;
        i2c_start();
        write_byte(8'hD0, a0);
        write_byte(8'h1F, a1);
        i2c_start();
        write_byte(8'hD1, a2);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        i2c_stop();
        clks(4);
        chk("rd_ack_addr", 32'(a2), 32'd0);
        chk("rd_byte0",    32'(d0), 32'hF0);
        chk("rd_byte1",    32'(d1), 32'(exp_b1));
        chk("rd_nack_cnt", 32'(nack_n - s_nack), 32'd1);

        // Address mismatch: slave must stay silent
        s_oe = oe_n; s_busy = busy_n;
        i2c_start();
        write_byte(8'hD2, a0);
        write_byte(8'h55, a1);
        write_byte(8'hAA, a2);
        i2c_stop();
        clks(4);
        chk("mis_ack_dev", 32'(a0), 32'd1);
        chk("mis_ack_d1",  32'(a1), 32'd1);
        chk("mis_oe_cyc",  32'(oe_n - s_oe), 32'd0);
        chk("mis_busy",    32'(busy_n - s_busy), 32'd0);

        // Host/I2C write collision on reg 3
        s_stb = stb_n; s_coll = coll_n;
        i2c_start();
        write_byte(8'hD0, a0);
        write_byte(8'h03, a1);
        write_byte_coll(8'hAA, a2);
        i2c_stop();
        clks(4);
        chk("coll_ack",   32'(a2), 32'd0);
        chk("coll_cnt",   32'(coll_n - s_coll), 32'd1);
        chk("coll_stb",   32'(stb_n - s_stb), 32'd1);
        rd_reg(5'h03, d0);
        chk("coll_reg3",  32'(d0), 32'hAA);

        // Reset in the middle of a read while the slave pulls SDA low
        host_wr(5'h07, 8'h3C);
        i2c_start();
        write_byte(8'hD0, a0);
        write_byte(8'h07, a1);
        i2c_start();
        write_byte(8'hD1, a2);
        chk("rst_mid_drive", 32'(O_SDA_OE), 32'd1);
        #2 RST_n = 1'b0;
        #1 chk("rst_mid_oe", 32'(O_SDA_OE), 32'd0);
        clks(2);
        RST_n = 1'b1;
        clks(2);
        s_oe = oe_n; s_busy = busy_n;
        write_byte(8'hD0, a0);
        write_byte(8'h07, a1);
        i2c_stop();
        clks(4);
        chk("rst_ign_ack",  32'(a0), 32'd1);
        chk("rst_ign_oe",   32'(oe_n - s_oe), 32'd0);
        chk("rst_ign_busy", 32'(busy_n - s_busy), 32'd0);
        rd_reg(5'h1F, d0);
        chk("rst_reg_clr",  32'(d0), 32'h00);

        // Two data bytes in one write transaction
        s_stb = stb_n;
        i2c_start();
        write_byte(8'hD0, a0);
        write_byte(8'h05, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a2);
        i2c_stop();
        clks(4);
        chk("two_wr_stb", 32'(stb_n - s_stb), 32'd2);
        rd_reg(5'h05, d0);
        chk("two_wr_reg5", 32'(d0), 32'(exp_r5));
        rd_reg(5'h06, d1);
        chk("two_wr_reg6", 32'(d1), 32'(exp_r6));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
